// File: rtl/serial_rx_align.sv
// Multi-lane serial-to-parallel receiver: per-lane comma hunt, word alignment,
// lock tracking and optional loss-of-sync after a run of non-comma words.
module serial_rx_align #(
  parameter int               WIDTH      = 8,
  parameter int               LANES      = 2,
  parameter logic [WIDTH-1:0] COMMA      = 8'hBC,
  parameter int               LOCK_COUNT = 4,
  parameter int               MAX_GAP    = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [LANES-1:0]       data_in,
  output logic [LANES*WIDTH-1:0] data_out,
  output logic [LANES-1:0]       valid_out,
  output logic [LANES-1:0]       locked,
  output logic                   all_locked,
  output logic [2*LANES-1:0]     dbg_state
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CW = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
  localparam int GW = (MAX_GAP < 1) ? 1 : $clog2(MAX_GAP + 1);
  localparam logic [CW-1:0] LOCK_CNT_C = CW'(LOCK_COUNT);
  localparam logic [GW-1:0] MAX_GAP_C  = GW'(MAX_GAP);

  typedef enum logic [1:0] {
    S_SEARCH = 2'd0,
    S_ALIGN  = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  // valid_out is a one-clock pulse with no backpressure: the consumer must take
  // data_out on every cycle valid_out is high, data_out holds until the next word.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_sr, w_sr_next, r_data, w_data_nxt;
    logic [BW-1:0]    r_bit_cnt, w_bit_cnt_nxt;
    logic [CW-1:0]    r_comma_cnt, w_comma_cnt_nxt;
    logic [GW-1:0]    r_gap_cnt, w_gap_cnt_nxt;
    logic             r_valid, w_valid_nxt;
    logic             w_boundary, w_is_comma;

    assign w_sr_next  = {r_sr[WIDTH-2:0], data_in[g]};
    assign w_boundary = (r_bit_cnt == BW'(WIDTH - 1));
    assign w_is_comma = (w_sr_next == COMMA);

    always_comb begin
      w_state_nxt     = r_state;
      w_bit_cnt_nxt   = w_boundary ? '0 : r_bit_cnt + BW'(1);
      w_comma_cnt_nxt = r_comma_cnt;
      w_gap_cnt_nxt   = r_gap_cnt;
      w_data_nxt      = r_data;
      w_valid_nxt     = 1'b0;
      case (r_state)
        S_SEARCH: begin
          // A match fixes the word phase: the next bit is bit 0 of a word.
          if (w_is_comma) begin
            w_bit_cnt_nxt   = '0;
            w_comma_cnt_nxt = CW'(1);
            w_gap_cnt_nxt   = '0;
            w_state_nxt     = (LOCK_COUNT == 1) ? S_LOCKED : S_ALIGN;
          end
        end
        S_ALIGN: begin
          if (w_boundary) begin
            if (w_is_comma) begin
              w_comma_cnt_nxt = r_comma_cnt + CW'(1);
              if (w_comma_cnt_nxt == LOCK_CNT_C) w_state_nxt = S_LOCKED;
            end else begin
              w_comma_cnt_nxt = '0;
              w_state_nxt     = S_SEARCH;
            end
          end
        end
        S_LOCKED: begin
          if (w_boundary) begin
            if (w_is_comma) begin
              w_gap_cnt_nxt = '0;
            end else begin
              w_data_nxt    = w_sr_next;
              w_valid_nxt   = 1'b1;
              w_gap_cnt_nxt = r_gap_cnt + GW'(1);
              // The word that exhausts the gap budget is still delivered.
              if ((MAX_GAP != 0) && (w_gap_cnt_nxt == MAX_GAP_C)) begin
                w_gap_cnt_nxt   = '0;
                w_comma_cnt_nxt = '0;
                w_state_nxt     = S_SEARCH;
              end
            end
          end
        end
        default: w_state_nxt = S_SEARCH;
      endcase
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        r_state     <= S_SEARCH;
        r_sr        <= '0;
        r_bit_cnt   <= '0;
        r_comma_cnt <= '0;
        r_gap_cnt   <= '0;
        r_data      <= '0;
        r_valid     <= 1'b0;
      end else begin
        r_state     <= w_state_nxt;
        r_sr        <= w_sr_next;
        r_bit_cnt   <= w_bit_cnt_nxt;
        r_comma_cnt <= w_comma_cnt_nxt;
        r_gap_cnt   <= w_gap_cnt_nxt;
        r_data      <= w_data_nxt;
        r_valid     <= w_valid_nxt;
      end
    end

    assign data_out[g*WIDTH +: WIDTH] = r_data;
    assign valid_out[g]               = r_valid;
    assign locked[g]                  = (r_state == S_LOCKED);
    assign dbg_state[2*g +: 2]        = r_state;
  end

  assign all_locked = &locked;

endmodule

// File: tb/tb_serial_rx_align.sv
// Directed bench for serial_rx_align: default instance (no loss detection) and a
// MAX_GAP=2 instance sharing clock and reset.
module tb_serial_rx_align;

  localparam int W = 8;
  localparam int L = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic [L-1:0]   din_a, din_b;
  logic [L*W-1:0] dout_a, dout_b;
  logic [L-1:0]   vld_a, vld_b, lk_a, lk_b;
  logic           all_a, all_b;
  logic [2*L-1:0] st_a, st_b;

  int n_cmp = 0;
  int n_err = 0;
  int pulses_a[L];
  int pulses_b[L];

  serial_rx_align #(.WIDTH(W), .LANES(L), .COMMA(8'hBC), .LOCK_COUNT(4), .MAX_GAP(0)) dut_a (
    .clk(clk), .reset(reset), .data_in(din_a), .data_out(dout_a), .valid_out(vld_a),
    .locked(lk_a), .all_locked(all_a), .dbg_state(st_a)
  );

  serial_rx_align #(.WIDTH(W), .LANES(L), .COMMA(8'hBC), .LOCK_COUNT(4), .MAX_GAP(2)) dut_b (
    .clk(clk), .reset(reset), .data_in(din_b), .data_out(dout_b), .valid_out(vld_b),
    .locked(lk_b), .all_locked(all_b), .dbg_state(st_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One bit per lane on each DUT; outputs sampled 1 time unit after the edge.
  task automatic tick(input logic [L-1:0] a, input logic [L-1:0] b);
    din_a = a;
    din_b = b;
    @(posedge clk);
    #1;
    for (int i = 0; i < L; i++) begin
      pulses_a[i] += int'(vld_a[i]);
      pulses_b[i] += int'(vld_b[i]);
    end
  endtask

  task automatic clr_pulses();
    for (int i = 0; i < L; i++) begin
      pulses_a[i] = 0;
      pulses_b[i] = 0;
    end
  endtask

  // Sends one word per lane to the selected DUT, MSB first; the other DUT idles at 0.
  task automatic words(input bit sel_b, input logic [W-1:0] w0, input logic [W-1:0] w1);
    clr_pulses();
    for (int k = W - 1; k >= 0; k--) begin
      if (sel_b) tick('0, {w1[k], w0[k]});
      else       tick({w1[k], w0[k]}, '0);
    end
  endtask

  task automatic lane_chk(input string tag, input bit sel_b, input int ln,
                          input logic ev, input logic [W-1:0] ed, input logic el);
    if (sel_b) begin
      check({tag, "_valid"},  vld_b[ln], ev);
      check({tag, "_data"},   dout_b[ln*W +: W], ed);
      check({tag, "_pulses"}, pulses_b[ln], ev);
      check({tag, "_locked"}, lk_b[ln], el);
    end else begin
      check({tag, "_valid"},  vld_a[ln], ev);
      check({tag, "_data"},   dout_a[ln*W +: W], ed);
      check({tag, "_pulses"}, pulses_a[ln], ev);
      check({tag, "_locked"}, lk_a[ln], el);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick('0, '0);
    tick('0, '0);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    din_a = '0;
    din_b = '0;
    clr_pulses();

    // Reset then idle
    do_reset();
    check("rst_dout_a", dout_a, '0);
    check("rst_vld_a",  vld_a, '0);
    check("rst_lk_a",   lk_a, '0);
    check("rst_all_a",  all_a, 1'b0);
    check("rst_st_a",   st_a, '0);
    check("rst_dout_b", dout_b, '0);
    check("rst_lk_b",   lk_b, '0);

    // Lock and data on lane 0, lane 1 idle
    words(0, 8'hBC, 8'h00);
    words(0, 8'hBC, 8'h00);
    words(0, 8'hBC, 8'h00);
    lane_chk("lk_bc3", 0, 0, 1'b0, 8'h00, 1'b0);
    check("lk_bc3_state", st_a[1:0], 2'd1);
    words(0, 8'hBC, 8'h00);
    lane_chk("lk_bc4", 0, 0, 1'b0, 8'h00, 1'b1);
    words(0, 8'hFF, 8'h00);
    lane_chk("lk_ff", 0, 0, 1'b1, 8'hFF, 1'b1);
    words(0, 8'hEE, 8'h00);
    lane_chk("lk_ee", 0, 0, 1'b1, 8'hEE, 1'b1);
    words(0, 8'hDD, 8'h00);
    lane_chk("lk_dd", 0, 0, 1'b1, 8'hDD, 1'b1);
    words(0, 8'hBC, 8'h00);
    lane_chk("lk_bc5", 0, 0, 1'b0, 8'hDD, 1'b1);
    words(0, 8'hAA, 8'h00);
    lane_chk("lk_aa", 0, 0, 1'b1, 8'hAA, 1'b1);
    lane_chk("lk_l1", 0, 1, 1'b0, 8'h00, 1'b0);
    check("lk_all", all_a, 1'b0);
    clr_pulses();
    tick('0, '0);
    check("lk_aa_pulse_end", vld_a[0], 1'b0);

    // Misaligned start: lane 1 sees 101 first, lane 0 sees 000
    do_reset();
    tick(2'b10, '0);
    tick(2'b00, '0);
    tick(2'b10, '0);
    words(0, 8'hBC, 8'hBC);
    words(0, 8'hBC, 8'hBC);
    words(0, 8'hBC, 8'hBC);
    check("mis_bc3_lk", lk_a, 2'b00);
    words(0, 8'hBC, 8'hBC);
    check("mis_bc4_lk", lk_a, 2'b11);
    check("mis_bc4_all", all_a, 1'b1);
    words(0, 8'hBC, 8'h5A);
    lane_chk("mis_5a_l1", 0, 1, 1'b1, 8'h5A, 1'b1);
    lane_chk("mis_5a_l0", 0, 0, 1'b0, 8'h00, 1'b1);
    check("mis_5a_all", all_a, 1'b1);

    // Broken comma run on lane 0
    do_reset();
    words(0, 8'hBC, 8'h00);
    words(0, 8'hBC, 8'h00);
    words(0, 8'h00, 8'h00);
    check("brk_00_lk", lk_a[0], 1'b0);
    check("brk_00_state", st_a[1:0], 2'd0);
    words(0, 8'hBC, 8'h00);
    words(0, 8'hBC, 8'h00);
    words(0, 8'hBC, 8'h00);
    check("brk_bc3_lk", lk_a[0], 1'b0);
    words(0, 8'hBC, 8'h00);
    check("brk_bc4_lk", lk_a[0], 1'b1);
    words(0, 8'h33, 8'h00);
    lane_chk("brk_33", 0, 0, 1'b1, 8'h33, 1'b1);

    // Reset mid-word: three bits of 8'h77 (0,1,1) then reset
    clr_pulses();
    tick(2'b00, '0);
    tick(2'b01, '0);
    tick(2'b01, '0);
    reset = 1'b1;
    tick('0, '0);
    reset = 1'b0;
    check("mid_pulses", pulses_a[0], 0);
    check("mid_vld", vld_a, '0);
    check("mid_lk", lk_a, '0);
    check("mid_dout", dout_a, '0);
    check("mid_all", all_a, 1'b0);

    // Loss of sync on the MAX_GAP=2 instance
    do_reset();
    words(1, 8'hBC, 8'h00);
    words(1, 8'hBC, 8'h00);
    words(1, 8'hBC, 8'h00);
    words(1, 8'hBC, 8'h00);
    check("gap_bc4_lk", lk_b[0], 1'b1);
    words(1, 8'hFF, 8'h00);
    lane_chk("gap_ff", 1, 0, 1'b1, 8'hFF, 1'b1);
    words(1, 8'hEE, 8'h00);
    lane_chk("gap_ee", 1, 0, 1'b1, 8'hEE, 1'b0);
    words(1, 8'hDD, 8'h00);
    lane_chk("gap_dd", 1, 0, 1'b0, 8'hEE, 1'b0);
    words(1, 8'hBC, 8'h00);
    words(1, 8'hBC, 8'h00);
    words(1, 8'hBC, 8'h00);
    check("gap_re_bc3_lk", lk_b[0], 1'b0);
    words(1, 8'hBC, 8'h00);
    check("gap_re_bc4_lk", lk_b[0], 1'b1);
    check("gap_re_pulses", pulses_b[0], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
